hazard_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RISC-V core. Consumes the ID-stage operand

---
 rtl/hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RISC-V core.
//
// Looks at the ID-stage operand fields, the EX-stage outputs of the ID/EX
// register and the data-memory handshake. It drives stall/flush controls for
// the PC, IF/ID, ID/EX and EX/MEM registers, tracks data-memory wait states
// with a watchdog, and keeps saturating stall/flush performance counters.
//
// Ports
//   clk, rst_n                  core clock, async active-low reset
//   id_rs1/id_rs2, *_used       source registers of the instruction in ID
//   ex_rd, ex_RegWEn, ex_MemRead destination/control of the instruction in EX
//   ex_PCSel                    taken branch/jump resolved in EX
//   mem_req, mem_ready          data-memory handshake of the MEM stage
//   clr_cnt                     synchronous clear of both perf counters
//   pc_stall .. ex_mem_stall    combinational pipeline controls
//   mem_timeout                 sticky watchdog flag (cleared by rst_n only)
//   stall_cnt, flush_cnt        saturating performance counters
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_RegWEn,
    input  logic             ex_MemRead,
    input  logic             ex_PCSel,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_cnt,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [TO_W-1:0]  WAIT_MAX = {TO_W{1'b1}};
    localparam logic [TO_W-1:0]  TO_LIM   = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0]  WAIT_ONE = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    state_e           state_q, state_d;
    logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic freeze_s;
    logic branch_s;
    logic src_hit_s;
    logic loaduse_s;

    // Hazard classification; freeze dominates branch, branch dominates load-use.
    always_comb begin
        freeze_s  = mem_req & ~mem_ready;
        branch_s  = ~freeze_s & ex_PCSel;
        src_hit_s = (id_rs1_used & (id_rs1 == ex_rd)) |
                    (id_rs2_used & (id_rs2 == ex_rd));
        loaduse_s = ~freeze_s & ~ex_PCSel & ex_MemRead & ex_RegWEn &
                    (ex_rd != 5'd0) & src_hit_s;
    end

    // Pipeline controls: purely combinational so they act in the same cycle,
    // including while rst_n is asserted.
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        if (freeze_s) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (branch_s) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
        end else if (loaduse_s) begin
            // One bubble into EX; next cycle re-evaluates with the bubble in EX.
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end else begin
            pc_stall     = 1'b0;
        end
    end

    // Memory-wait FSM next state and watchdog counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (freeze_s) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = {TO_W{1'b0}};
                end
            end
            ST_WAIT: begin
                if (!freeze_s) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = {TO_W{1'b0}};
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end else begin
                    wait_cnt_d = wait_cnt_q;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = {TO_W{1'b0}};
            end
        endcase
        // Flag is only an indication; it never releases the freeze.
        mem_timeout_d = mem_timeout_q |
                        ((state_q == ST_WAIT) && (wait_cnt_q == TO_LIM));
    end

    // Performance counters; clear has priority over increment.
    always_comb begin
        if (clr_cnt) begin
            stall_cnt_d = {CNT_W{1'b0}};
            flush_cnt_d = {CNT_W{1'b0}};
        end else begin
            stall_cnt_d = pc_stall    ? sat_inc(stall_cnt_q) : stall_cnt_q;
            flush_cnt_d = if_id_flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
        end
    end

    // State registers for FSM, watchdog and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= {TO_W{1'b0}};
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl (CNT_W=4, MEM_TIMEOUT=4). Control outputs
// are packed as {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
// id_ex_flush, ex_mem_stall}.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_W = 4;

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LU     = 6'b110010;
    localparam logic [5:0] C_BR     = 6'b001010;
    localparam logic [5:0] C_FREEZE = 6'b110101;

    logic             clk;
    logic             rst_n;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_rs1_used, id_rs2_used;
    logic             ex_RegWEn, ex_MemRead, ex_PCSel;
    logic             mem_req, mem_ready, clr_cnt;
    logic             pc_stall, if_id_stall, if_id_flush;
    logic             id_ex_stall, id_ex_flush, ex_mem_stall;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [5:0]       ctrl;

    int n_cmp = 0;
    int n_err = 0;

    hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_RegWEn(ex_RegWEn), .ex_MemRead(ex_MemRead),
        .ex_PCSel(ex_PCSel), .mem_req(mem_req), .mem_ready(mem_ready),
        .clr_cnt(clr_cnt),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
        .ex_mem_stall(ex_mem_stall), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and land just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_RegWEn = 1'b0; ex_MemRead = 1'b0; ex_PCSel = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic set_lw_x5();
        ex_MemRead = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_rs1_used = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #2;
        chk("rst_ctrl", 32'(ctrl), 32'(C_NONE));
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        // Controls follow inputs during reset.
        mem_req = 1'b1;
        #1;
        chk("rst_comb_freeze", 32'(ctrl), 32'(C_FREEZE));
        mem_req = 1'b0;
        #20;
        rst_n = 1'b1;
        tick();
        chk("idle_stall_cnt", 32'(stall_cnt), 32'd0);

        // 1. load-use on rs1
        set_lw_x5();
        #1;
        chk("lu_rs1_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_flush_cnt", 32'(flush_cnt), 32'd0);
        // load-use via rs2 path
        id_rs1_used = 1'b0; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        #1;
        chk("lu_rs2_ctrl", 32'(ctrl), 32'(C_LU));

        // 2. no hazard cases
        idle_inputs();
        ex_MemRead = 1'b1; ex_RegWEn = 1'b1; ex_rd = 5'd0;
        id_rs1 = 5'd0; id_rs1_used = 1'b1;
        #1;
        chk("rd0_ctrl", 32'(ctrl), 32'(C_NONE));
        idle_inputs();
        set_lw_x5();
        id_rs1_used = 1'b0;
        #1;
        chk("unused_ctrl", 32'(ctrl), 32'(C_NONE));
        id_rs1_used = 1'b1; ex_RegWEn = 1'b0;
        #1;
        chk("nowen_ctrl", 32'(ctrl), 32'(C_NONE));
        ex_RegWEn = 1'b1; ex_MemRead = 1'b0;
        #1;
        chk("alu_fwd_ctrl", 32'(ctrl), 32'(C_NONE));
        ex_MemRead = 1'b1; id_rs1 = 5'd6;
        #1;
        chk("reg_diff_ctrl", 32'(ctrl), 32'(C_NONE));

        // 3. branch beats load-use
        id_rs1 = 5'd5; ex_PCSel = 1'b1;
        #1;
        chk("br_lu_ctrl", 32'(ctrl), 32'(C_BR));
        tick();
        chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(stall_cnt), 32'd1);

        // 4. freeze for 3 cycles; branch and load-use ignored
        mem_req = 1'b1; mem_ready = 1'b0;
        #1;
        chk("frz_ctrl", 32'(ctrl), 32'(C_FREEZE));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_state_wait", 32'(dut.state_q), 32'd1);
        end
        chk("frz_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("frz_flush_cnt", 32'(flush_cnt), 32'd1);
        idle_inputs();
        mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        chk("ready_ctrl", 32'(ctrl), 32'(C_NONE));
        tick();
        chk("ready_state_run", 32'(dut.state_q), 32'd0);
        chk("ready_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("ready_timeout", 32'(mem_timeout), 32'd0);

        // 5. watchdog: flag set at the end of the 4th WAIT cycle
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("to_before", 32'(mem_timeout), 32'd0);
        tick();
        chk("to_set", 32'(mem_timeout), 32'd1);
        chk("to_stall_cnt", 32'(stall_cnt), 32'd9);
        chk("to_still_frozen", 32'(ctrl), 32'(C_FREEZE));
        // 6. saturate stall counter
        for (int i = 0; i < 6; i++) tick();
        chk("sat_reach", 32'(stall_cnt), 32'd15);
        tick();
        tick();
        chk("sat_hold", 32'(stall_cnt), 32'd15);
        mem_ready = 1'b1;
        tick();
        chk("to_sticky", 32'(mem_timeout), 32'd1);
        chk("to_state_run", 32'(dut.state_q), 32'd0);

        // clear wins over increment
        mem_ready = 1'b0; clr_cnt = 1'b1;
        tick();
        chk("clr_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("clr_flush_cnt", 32'(flush_cnt), 32'd0);
        clr_cnt = 1'b0;
        tick();
        chk("post_clr_cnt", 32'(stall_cnt), 32'd1);
        chk("pre_rst_wait", 32'(dut.state_q), 32'd1);

        // async reset mid-WAIT
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(dut.state_q), 32'd0);
        chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("arst_timeout", 32'(mem_timeout), 32'd0);
        chk("arst_ctrl_comb", 32'(ctrl), 32'(C_FREEZE));
        #5;
        idle_inputs();
        rst_n = 1'b1;
        tick();
        chk("end_state", 32'(dut.state_q), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
